apb_to_axil_bridge: RTL and testbench

- Reverse-direction bridge: APB4 completer port on the upstream side, AXI4-Lite manager port on the downstream side.
- Each APB transfer is converted into exactly one AXI4-Lite write (AW+W+B) or read (AR+R) transaction.
- APB wait states (pready low) are inserted until the AXI response returns.
- Lets an APB-only host subsystem reach AXI4-Lite peripherals. Single outstanding transaction, no buffering beyond one request.

---
 rtl/apb_axil_pkg.sv | 24 ++
 rtl/apb_to_axil_bridge.sv | 166 ++++++++++++++++
 tb/tb_apb_to_axil_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_axil_pkg.sv
// Shared types and constants for the APB4-to-AXI4-Lite bridge.
// Holds the FSM state encoding, the AXI response codes and the error-mapping helper.
package apb_axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both carry bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/apb_to_axil_bridge.sv
// APB4 completer to AXI4-Lite manager bridge with a single outstanding transfer.
// The APB transfer is held in wait states until the AXI response returns.
module apb_to_axil_bridge
  import apb_axil_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  // APB completer
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [addrWidth-1:0]     paddr,
  input  logic [dataWidth-1:0]     pwdata,
  input  logic [dataWidth/8-1:0]   pstrb,
  input  logic [2:0]               pprot,
  output logic [dataWidth-1:0]     prdata,
  output logic                     pready,
  output logic                     pslverr,
  // AXI4-Lite write channels
  output logic                     awvalid,
  input  logic                     awready,
  output logic [addrWidth-1:0]     awaddr,
  output logic [2:0]               awprot,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [dataWidth-1:0]     wdata,
  output logic [dataWidth/8-1:0]   wstrb,
  input  logic                     bvalid,
  output logic                     bready,
  input  logic [1:0]               bresp,
  // AXI4-Lite read channels
  output logic                     arvalid,
  input  logic                     arready,
  output logic [addrWidth-1:0]     araddr,
  output logic [2:0]               arprot,
  input  logic                     rvalid,
  output logic                     rready,
  input  logic [dataWidth-1:0]     rdata,
  input  logic [1:0]               rresp,
  // FSM state for observation
  output logic [2:0]               dbg_state
);

  // Handshake rule on every AXI channel: a transfer happens on a rising edge where
  // valid & ready are both high; a raised valid and its payload hold until then.

  bridge_state_t              r_state;
  bridge_state_t              w_next;

  logic [addrWidth-1:0]       r_paddr;
  logic [dataWidth-1:0]       r_pwdata;
  logic [dataWidth/8-1:0]     r_pstrb;
  logic [2:0]                 r_pprot;
  logic                       r_aw_done;
  logic                       r_w_done;
  logic                       r_pslverr;
  logic [dataWidth-1:0]       r_prdata;

  logic                       w_setup;
  logic                       w_aw_hs;
  logic                       w_w_hs;

  assign w_setup = psel & ~penable;
  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_next = pwrite ? WR_REQ : RD_REQ;
      // A handshake completing this cycle counts as done.
      WR_REQ:  if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_next = WR_RESP;
      WR_RESP: if (bvalid) w_next = DONE;
      RD_REQ:  if (arready) w_next = RD_RESP;
      RD_RESP: if (rvalid) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    case (r_state)
      WR_REQ: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
      end
      WR_RESP: bready  = 1'b1;
      RD_REQ:  arvalid = 1'b1;
      RD_RESP: rready  = 1'b1;
      DONE: begin
        pready  = 1'b1;
        pslverr = r_pslverr;
      end
      default: ;
    endcase
  end

  // Request capture, per-channel completion flags and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_paddr  <= paddr;
            r_pwdata <= pwdata;
            r_pstrb  <= pstrb;
            r_pprot  <= pprot;
          end
        end
        WR_REQ: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        WR_RESP: if (bvalid) r_pslverr <= resp_is_err(bresp);
        RD_RESP: begin
          if (rvalid) begin
            r_prdata  <= rdata;
            r_pslverr <= resp_is_err(rresp);
          end
        end
        DONE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign awaddr    = r_paddr;
  assign awprot    = r_pprot;
  assign wdata     = r_pwdata;
  assign wstrb     = r_pstrb;
  assign araddr    = r_paddr;
  assign arprot    = r_pprot;
  assign prdata    = r_prdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_apb_to_axil_bridge.sv
// Bench for apb_to_axil_bridge: APB driver tasks, a stalling AXI4-Lite responder,
// a transfer-level reference model with an expected read-data queue, and a summary.
module tb_apb_to_axil_bridge;
  import apb_axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [SW-1:0] pstrb = '0;
  logic [2:0]    pprot = '0;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic          awvalid, awready = 1'b0;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid, wready = 1'b0;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid = 1'b0, bready;
  logic [1:0]    bresp = '0;
  logic          arvalid, arready = 1'b0;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid = 1'b0, rready;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic [2:0]    dbg_state;

  apb_to_axil_bridge #(.dataWidth(DW), .addrWidth(AW)) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_prdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- AXI responder configuration ----------------
  int s_aw = 0, s_w = 0, s_b = 0, s_ar = 0, s_r = 0;
  logic [1:0]    cfg_bresp = RESP_OKAY;
  logic [1:0]    cfg_rresp = RESP_OKAY;
  logic [DW-1:0] cfg_rdata = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [SW-1:0] exp_strb = '0;
  logic [2:0]    exp_prot = '0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic          pend_aw = 0, pend_w = 0, pend_ar = 0;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [DW-1:0] prev_wdata;
  logic [SW-1:0] prev_wstrb;
  logic [2:0]    prev_awprot, prev_arprot;

  // Responder and protocol monitor run on the falling edge, away from the DUT edge.
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      pend_aw = 0; pend_w = 0; pend_ar = 0;
    end else begin
      check("excl_ar_aw_w", {63'd0, arvalid & (awvalid | wvalid)}, 64'd0);
      check("pslverr_wo_pready", {63'd0, pslverr & ~pready}, 64'd0);
      if (pend_aw) begin
        check("aw_stable_valid", {63'd0, awvalid}, 64'd1);
        check("aw_stable_addr", {32'd0, awaddr}, {32'd0, prev_awaddr});
        check("aw_stable_prot", {61'd0, awprot}, {61'd0, prev_awprot});
      end
      if (pend_w) begin
        check("w_stable_valid", {63'd0, wvalid}, 64'd1);
        check("w_stable_data", {32'd0, wdata}, {32'd0, prev_wdata});
        check("w_stable_strb", {60'd0, wstrb}, {60'd0, prev_wstrb});
      end
      if (pend_ar) begin
        check("ar_stable_valid", {63'd0, arvalid}, 64'd1);
        check("ar_stable_addr", {32'd0, araddr}, {32'd0, prev_araddr});
        check("ar_stable_prot", {61'd0, arprot}, {61'd0, prev_arprot});
      end

      awready = awvalid && (aw_cnt >= s_aw);
      wready  = wvalid  && (w_cnt  >= s_w);
      arready = arvalid && (ar_cnt >= s_ar);
      bvalid  = bready  && (b_cnt  >= s_b);
      rvalid  = rready  && (r_cnt  >= s_r);
      bresp   = cfg_bresp;
      rresp   = cfg_rresp;
      rdata   = cfg_rdata;

      if (awvalid && awready) begin
        n_aw++; aw_cnt = 0;
        check("awaddr", {32'd0, awaddr}, {32'd0, exp_addr});
        check("awprot", {61'd0, awprot}, {61'd0, exp_prot});
      end else if (awvalid) aw_cnt++;
      if (wvalid && wready) begin
        n_w++; w_cnt = 0;
        check("wdata", {32'd0, wdata}, {32'd0, exp_wdata});
        check("wstrb", {60'd0, wstrb}, {60'd0, exp_strb});
      end else if (wvalid) w_cnt++;
      if (arvalid && arready) begin
        n_ar++; ar_cnt = 0;
        check("araddr", {32'd0, araddr}, {32'd0, exp_addr});
        check("arprot", {61'd0, arprot}, {61'd0, exp_prot});
      end else if (arvalid) ar_cnt++;
      if (bvalid) begin n_b++; b_cnt = 0; end
      else if (bready) b_cnt++;
      if (rvalid) begin n_r++; r_cnt = 0; end
      else if (rready) r_cnt++;

      pend_aw = awvalid & ~awready; prev_awaddr = awaddr; prev_awprot = awprot;
      pend_w  = wvalid & ~wready;   prev_wdata = wdata;   prev_wstrb = wstrb;
      pend_ar = arvalid & ~arready; prev_araddr = araddr; prev_arprot = arprot;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb_idle(input int n);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    repeat (n) @(posedge clk);
  endtask

  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [2:0] p,
                          output int lat, output logic err, output logic [DW-1:0] rd);
    int t0;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    t0 = cyc;
    @(negedge clk);
    check("pready_in_setup", {63'd0, pready}, 64'd0);
    @(posedge clk); #1;
    penable = 1;
    lat = -1; err = 0; rd = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pready) begin
        lat = cyc - t0; err = pslverr; rd = prdata;
        break;
      end
    end
    if (lat < 0) check("pready_timeout", 64'd1, 64'd0);
  endtask

  // One transfer compared against the transfer-level model.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] p);
    int lat, exp_lat;
    logic err, exp_err;
    logic [DW-1:0] rd, exp_rd;
    exp_addr = a; exp_wdata = d; exp_strb = s; exp_prot = p;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    if (wr) begin
      exp_lat = 3 + ((s_aw > s_w) ? s_aw : s_w) + s_b;
      exp_err = (cfg_bresp == RESP_SLVERR) || (cfg_bresp == RESP_DECERR);
    end else begin
      exp_lat = 3 + s_ar + s_r;
      exp_err = (cfg_rresp == RESP_SLVERR) || (cfg_rresp == RESP_DECERR);
      exp_q.push_back(cfg_rdata);
    end
    apb_xfer(wr, a, d, s, p, lat, err, rd);
    if (lat < 0) return;
    if (!wr) model_prdata = exp_q.pop_front();
    exp_rd = model_prdata;
    check(wr ? "wr_latency" : "rd_latency", lat, exp_lat);
    check(wr ? "wr_pslverr" : "rd_pslverr", {63'd0, err}, {63'd0, exp_err});
    check(wr ? "prdata_hold" : "rd_prdata", {32'd0, rd}, {32'd0, exp_rd});
    check("n_aw", n_aw, wr ? 1 : 0);
    check("n_w",  n_w,  wr ? 1 : 0);
    check("n_b",  n_b,  wr ? 1 : 0);
    check("n_ar", n_ar, wr ? 0 : 1);
    check("n_r",  n_r,  wr ? 0 : 1);
  endtask

  task automatic set_stalls(input int aw_s, input int w_s, input int b_s, input int ar_s, input int r_s);
    s_aw = aw_s; s_w = w_s; s_b = b_s; s_ar = ar_s; s_r = r_s;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {61'd0, dbg_state}, {61'd0, IDLE});
    check("rst_pready", {63'd0, pready}, 64'd0);
    check("rst_pslverr", {63'd0, pslverr}, 64'd0);
    check("rst_prdata", {32'd0, prdata}, 64'd0);
    check("rst_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
    @(posedge clk); #1;
    rst = 0;

    // Zero-stall write
    set_stalls(0, 0, 0, 0, 0); cfg_bresp = RESP_OKAY;
    do_xfer(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010);
    apb_idle(1);

    // Read with arready stalled four cycles, SLVERR response
    set_stalls(0, 0, 0, 4, 0); cfg_rresp = RESP_SLVERR; cfg_rdata = 32'h1234_5678;
    do_xfer(0, 32'h0000_0024, 32'h0, 4'h0, 3'b000);
    apb_idle(2);

    // AW accepted at T1, W at T4, B at T5
    set_stalls(0, 3, 0, 0, 0); cfg_bresp = RESP_EXOKAY;
    do_xfer(1, 32'h0000_0100, 32'hA5A5_0F0F, 4'h0, 3'b001);

    // Back-to-back: DECERR write immediately followed by an OKAY read
    set_stalls(1, 0, 2, 0, 0); cfg_bresp = RESP_DECERR;
    do_xfer(1, 32'h0000_0200, 32'h0BAD_F00D, 4'h3, 3'b100);
    set_stalls(0, 0, 0, 1, 2); cfg_rresp = RESP_OKAY; cfg_rdata = 32'hCAFE_0001;
    do_xfer(0, 32'h0000_0204, 32'hFFFF_FFFF, 4'hF, 3'b000);
    apb_idle(1);

    // Reset while waiting for the write response
    set_stalls(0, 0, 50, 0, 0); cfg_bresp = RESP_OKAY;
    exp_addr = 32'h40; exp_wdata = 32'h1111_2222; exp_strb = 4'hF; exp_prot = 3'b000;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = exp_addr; pwdata = exp_wdata; pstrb = exp_strb; pprot = exp_prot;
    @(posedge clk); #1;
    penable = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bready) begin found = 1; break; end
    end
    check("reach_wr_resp", {63'd0, found}, 64'd1);
    @(posedge clk); #1;
    rst = 1; psel = 0; penable = 0;
    @(posedge clk); #1;
    rst = 0;
    model_prdata = '0;
    @(negedge clk);
    check("midrst_state", {61'd0, dbg_state}, {61'd0, IDLE});
    check("midrst_outs", {58'd0, awvalid, wvalid, arvalid, bready, rready, pready}, 64'd0);
    check("midrst_prdata", {32'd0, prdata}, 64'd0);
    set_stalls(0, 0, 0, 0, 1); cfg_rresp = RESP_EXOKAY; cfg_rdata = 32'h7777_8888;
    do_xfer(0, 32'h0000_0044, 32'h0, 4'hA, 3'b011);

    // Randomized transfers with random stalls and responses
    for (int k = 0; k < 40; k++) begin
      set_stalls($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      cfg_bresp = 2'($urandom_range(0, 3));
      cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata = $urandom;
      do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) apb_idle($urandom_range(0, 2));
    end
    apb_idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
